bsg_rr3_locking_arb: RTL

//  Three-requester round-robin arbiter with packet locking, feeding one registered output channel.

---
 rtl/bsg_rr3_locking_arb_if.sv | 26 ++
 rtl/bsg_rr3_locking_arb.sv | 132 +++++++++++++
 2 files changed

// File: rtl/bsg_rr3_locking_arb_if.sv
// Handshake bundle between three requesters, the arbiter and its downstream consumer.
// The slave modport is the arbiter's view; master is the environment's view.
interface bsg_rr3_locking_arb_if #(
    parameter int width_p = 4
);
    logic [2:0]           v_i;
    logic [3*width_p-1:0] data_i;
    logic [2:0]           last_i;
    logic [2:0]           ready_o;
    logic                 v_o;
    logic [width_p-1:0]   data_o;
    logic                 last_o;
    logic [1:0]           src_o;
    logic                 ready_i;
    logic                 idle_o;

    modport slave (
        input  v_i, data_i, last_i, ready_i,
        output ready_o, v_o, data_o, last_o, src_o, idle_o
    );

    modport master (
        output v_i, data_i, last_i, ready_i,
        input  ready_o, v_o, data_o, last_o, src_o, idle_o
    );
endinterface

// File: rtl/bsg_rr3_locking_arb.sv
// Three-way round-robin arbiter with optional packet locking, driving one registered
// output slot. The grant is held on the packet owner until its last beat when lock_p=1.
module bsg_rr3_locking_arb #(
    parameter int width_p = 4,
    parameter bit lock_p  = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    bsg_rr3_locking_arb_if.slave io
);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e             state_q, state_d;
    logic [1:0]         owner_q, owner_d;
    logic [1:0]         ptr_q, ptr_d;
    logic               v_q, v_d;
    logic [width_p-1:0] data_q, data_d;
    logic               last_q, last_d;
    logic [1:0]         src_q, src_d;

    logic               space;
    logic [2:0]         gnt;
    logic [2:0]         ready;
    logic               accept;
    logic [1:0]         sel;
    logic               sel_last;
    logic [width_p-1:0] sel_data;

    function automatic logic [1:0] wrap_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign space = ~v_q | io.ready_i;

    // Search starts one past the last packet's owner so each requester waits at most two grants.
    always_comb begin
        logic [1:0] cand;
        logic       found;
        gnt   = 3'b000;
        cand  = wrap_inc(ptr_q);
        found = 1'b0;
        if (state_q == LOCKED) begin
            gnt[owner_q] = 1'b1;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!found && io.v_i[cand]) begin
                    gnt[cand] = 1'b1;
                    found     = 1'b1;
                end
                cand = wrap_inc(cand);
            end
        end
    end

    // Ready is forced low during reset so no beat can be consumed while state is being cleared.
    assign ready  = gnt & {3{space & reset_n_i}};
    assign accept = |(io.v_i & ready);
    assign sel    = gnt[2] ? 2'd2 : (gnt[1] ? 2'd1 : 2'd0);

    always_comb begin
        case (sel)
            2'd1:    sel_data = io.data_i[width_p   +: width_p];
            2'd2:    sel_data = io.data_i[2*width_p +: width_p];
            default: sel_data = io.data_i[0         +: width_p];
        endcase
        sel_last = io.last_i[sel];
    end

    always_comb begin
        v_d     = v_q;
        data_d  = data_q;
        last_d  = last_q;
        src_d   = src_q;
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        if (accept) begin
            v_d    = 1'b1;
            data_d = sel_data;
            last_d = sel_last;
            src_d  = sel;
            if (lock_p) begin
                if (state_q == IDLE && !sel_last) begin
                    state_d = LOCKED;
                    owner_d = sel;
                end else if (state_q == LOCKED && sel_last) begin
                    state_d = IDLE;
                end
            end
            // The pointer only moves when a grant ends, so mid-packet beats do not shift priority.
            if (sel_last || !lock_p) begin
                ptr_d = sel;
            end
        end else if (io.ready_i) begin
            v_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            owner_q <= 2'd0;
            ptr_q   <= 2'd2;
            v_q     <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            src_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            v_q     <= v_d;
            data_q  <= data_d;
            last_q  <= last_d;
            src_q   <= src_d;
        end
    end

    assign io.ready_o = ready;
    assign io.v_o     = v_q;
    assign io.data_o  = data_q;
    assign io.last_o  = last_q;
    assign io.src_o   = src_q;
    assign io.idle_o  = ~(io.v_i[0] | io.v_i[1] | io.v_i[2]) & ~v_q & (state_q == IDLE);

    a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!reset_n_i) $onehot0(gnt));
    a_src_range:  assert property (@(posedge clk_i) disable iff (!reset_n_i) src_q != 2'd3);
    a_v_stall:    assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                   (v_q && !io.ready_i) |=> v_q);

endmodule
